// File: rtl/rv32_pipe_pkg.sv
// Shared types and constants for the RV32 pipeline boundary registers.
// Each boundary sizes its stage register from the payload/control structs below.
package rv32_pipe_pkg;

    localparam logic [31:0] NOP_CODE = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } if_id_data_t;

    typedef struct packed {
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [31:0] pc;
    } id_ex_data_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] bshift;
        logic [31:0] pc_ret;
        logic [31:0] data_store;
    } ex_mem_data_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] load_data;
        logic [31:0] pc_ret;
    } mem_wb_data_t;

    // All-zero control means no RF write and no memory access at every boundary.
    typedef struct packed {
        logic       rf_we;
        logic       mem_re;
        logic       mem_we;
        logic [1:0] mem_size;
        logic       load_sext;
    } ex_mem_ctrl_t;

    typedef struct packed {
        logic       rf_we;
        logic [1:0] wb_sel;
    } mem_wb_ctrl_t;

    localparam int unsigned IF_ID_DATA_W  = $bits(if_id_data_t);
    localparam int unsigned ID_EX_DATA_W  = $bits(id_ex_data_t);
    localparam int unsigned EX_MEM_DATA_W = $bits(ex_mem_data_t);
    localparam int unsigned MEM_WB_DATA_W = $bits(mem_wb_data_t);

    localparam int unsigned IF_ID_CTRL_W  = 1;
    localparam int unsigned ID_EX_CTRL_W  = 6;
    localparam int unsigned EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
    localparam int unsigned MEM_WB_CTRL_W = $bits(mem_wb_ctrl_t);

    localparam logic [IF_ID_CTRL_W-1:0]  IF_ID_CTRL_BUBBLE  = '0;
    localparam logic [ID_EX_CTRL_W-1:0]  ID_EX_CTRL_BUBBLE  = '0;
    localparam logic [EX_MEM_CTRL_W-1:0] EX_MEM_CTRL_BUBBLE = '0;
    localparam logic [MEM_WB_CTRL_W-1:0] MEM_WB_CTRL_BUBBLE = '0;

endpackage

// File: rtl/rv32_pipe_entry.sv
// One held pipeline entry: payload, control bundle, instruction word and valid bit.
// A bubble (or reset) clears it to safe values; load captures a new entry.
module rv32_pipe_entry #(
    parameter int unsigned       DATA_W      = 128,
    parameter int unsigned       CTRL_W      = 6,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
    parameter logic [31:0]       NOP_CODE    = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              bubble,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [31:0]       d_code,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl,
    output logic [31:0]       code
);

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= CTRL_BUBBLE;
            code  <= NOP_CODE;
        end else if (load) begin
            valid <= 1'b1;
            data  <= d_data;
            ctrl  <= d_ctrl;
            code  <= d_code;
        end
    end

endmodule

// File: rtl/rv32_pipe_stage_reg.sv
// Pipeline boundary register with valid/ready handshake, one-entry skid buffer,
// flush-to-bubble and a saturating stall counter.
module rv32_pipe_stage_reg
    import rv32_pipe_pkg::*;
#(
    parameter int unsigned       DATA_W      = EX_MEM_DATA_W,
    parameter int unsigned       CTRL_W      = EX_MEM_CTRL_W,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
    parameter logic [31:0]       NOP_CODE    = rv32_pipe_pkg::NOP_CODE,
    parameter int unsigned       CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [31:0]       in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [31:0]       out_code,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [31:0]       skid_code;

    logic acc_in;
    logic acc_out;
    logic main_free;
    logic main_load;
    logic main_bubble;
    logic main_from_skid;
    logic skid_load;
    logic skid_bubble;
    logic skid_valid_nxt;

    logic [DATA_W-1:0] main_d_data;
    logic [CTRL_W-1:0] main_d_ctrl;
    logic [31:0]       main_d_code;

    assign acc_in    = in_valid & in_ready;
    assign acc_out   = out_valid & out_ready;
    assign main_free = ~out_valid | out_ready;

    // Entry steering: flush kills both, a free main drains skid first to keep FIFO order.
    always_comb begin
        main_load      = 1'b0;
        main_bubble    = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_bubble    = 1'b0;
        skid_valid_nxt = skid_valid;
        if (flush) begin
            main_bubble    = 1'b1;
            skid_bubble    = 1'b1;
            skid_valid_nxt = 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                main_load      = 1'b1;
                main_from_skid = 1'b1;
                if (acc_in) begin
                    skid_load      = 1'b1;
                    skid_valid_nxt = 1'b1;
                end else begin
                    skid_bubble    = 1'b1;
                    skid_valid_nxt = 1'b0;
                end
            end else if (acc_in) begin
                main_load = 1'b1;
            end else begin
                main_bubble = 1'b1;
            end
        end else if (acc_in) begin
            skid_load      = 1'b1;
            skid_valid_nxt = 1'b1;
        end
    end

    assign main_d_data = main_from_skid ? skid_data : in_data;
    assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_d_code = main_from_skid ? skid_code : in_code;

    rv32_pipe_entry #(
        .DATA_W      (DATA_W),
        .CTRL_W      (CTRL_W),
        .CTRL_BUBBLE (CTRL_BUBBLE),
        .NOP_CODE    (NOP_CODE)
    ) u_main (
        .clk    (clk),
        .rst    (rst),
        .load   (main_load),
        .bubble (main_bubble),
        .d_data (main_d_data),
        .d_ctrl (main_d_ctrl),
        .d_code (main_d_code),
        .valid  (out_valid),
        .data   (out_data),
        .ctrl   (out_ctrl),
        .code   (out_code)
    );

    rv32_pipe_entry #(
        .DATA_W      (DATA_W),
        .CTRL_W      (CTRL_W),
        .CTRL_BUBBLE (CTRL_BUBBLE),
        .NOP_CODE    (NOP_CODE)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_load),
        .bubble (skid_bubble),
        .d_data (in_data),
        .d_ctrl (in_ctrl),
        .d_code (in_code),
        .valid  (skid_valid),
        .data   (skid_data),
        .ctrl   (skid_ctrl),
        .code   (skid_code)
    );

    // Ready is precomputed from the next skid state so it never sees out_ready combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready <= 1'b0;
        end else begin
            in_ready <= ~skid_valid_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rv32_pipe_stage_reg.sv
// Directed bench for rv32_pipe_stage_reg: reset, streaming, backpressure, flush,
// stall counter saturation (CNT_W=4) and reset with both entries held.
module tb_rv32_pipe_stage_reg;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned CTRL_W = 6;
    localparam int unsigned CNT_W  = 4;

    localparam logic [31:0] CODE_A = 32'h0050_0093;
    localparam logic [31:0] CODE_B = 32'h00A0_0113;
    localparam logic [31:0] CODE_C = 32'h0020_81B3;
    localparam logic [31:0] CODE_D = 32'h0030_0213;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic [31:0]       in_code;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [31:0]       out_code;
    logic [CNT_W-1:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    rv32_pipe_stage_reg #(
        .DATA_W      (DATA_W),
        .CTRL_W      (CTRL_W),
        .CTRL_BUBBLE (6'h00),
        .NOP_CODE    (NOP),
        .CNT_W       (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .out_code  (out_code),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] pay(input logic [31:0] c);
        return {c, ~c, c ^ 32'hA5A5_A5A5, c + 32'd1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] c, input logic [CTRL_W-1:0] k);
        in_valid = v;
        in_code  = c;
        in_ctrl  = k;
        in_data  = pay(c);
    endtask

    task automatic expect_bubble(input string tag);
        check({tag, "_valid"}, DATA_W'(out_valid), DATA_W'(0));
        check({tag, "_code"}, DATA_W'(out_code), DATA_W'(NOP));
        check({tag, "_ctrl"}, DATA_W'(out_ctrl), DATA_W'(0));
        check({tag, "_data"}, out_data, DATA_W'(0));
    endtask

    task automatic expect_entry(input string tag, input logic [31:0] c, input logic [CTRL_W-1:0] k);
        check({tag, "_valid"}, DATA_W'(out_valid), DATA_W'(1));
        check({tag, "_code"}, DATA_W'(out_code), DATA_W'(c));
        check({tag, "_ctrl"}, DATA_W'(out_ctrl), DATA_W'(k));
        check({tag, "_data"}, out_data, pay(c));
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 6'h00);

        // Reset held for two cycles, then released
        tick();
        tick();
        expect_bubble("rst");
        check("rst_in_ready", DATA_W'(in_ready), DATA_W'(0));
        check("rst_stall", DATA_W'(stall_cnt), DATA_W'(0));
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", DATA_W'(in_ready), DATA_W'(1));
        expect_bubble("post_rst");

        // Streaming, one entry per cycle
        out_ready = 1'b1;
        drive(1'b1, CODE_A, 6'h21);
        tick();
        expect_entry("stream_a", CODE_A, 6'h21);
        check("stream_a_rdy", DATA_W'(in_ready), DATA_W'(1));
        drive(1'b1, CODE_B, 6'h22);
        tick();
        expect_entry("stream_b", CODE_B, 6'h22);
        check("stream_b_rdy", DATA_W'(in_ready), DATA_W'(1));
        drive(1'b1, CODE_C, 6'h23);
        tick();
        expect_entry("stream_c", CODE_C, 6'h23);
        check("stream_c_rdy", DATA_W'(in_ready), DATA_W'(1));
        drive(1'b0, 32'h0, 6'h00);
        tick();
        expect_bubble("stream_end");
        check("stream_stall", DATA_W'(stall_cnt), DATA_W'(0));

        // Backpressure: A in main, B in skid, C held upstream
        out_ready = 1'b0;
        drive(1'b1, CODE_A, 6'h11);
        tick();
        expect_entry("bp_a", CODE_A, 6'h11);
        check("bp_a_rdy", DATA_W'(in_ready), DATA_W'(1));
        check("bp_a_stall", DATA_W'(stall_cnt), DATA_W'(0));
        drive(1'b1, CODE_B, 6'h12);
        tick();
        expect_entry("bp_b_held_a", CODE_A, 6'h11);
        check("bp_b_rdy", DATA_W'(in_ready), DATA_W'(0));
        check("bp_b_stall", DATA_W'(stall_cnt), DATA_W'(1));
        drive(1'b1, CODE_C, 6'h13);
        tick();
        check("bp_c_code", DATA_W'(out_code), DATA_W'(CODE_A));
        check("bp_c_rdy", DATA_W'(in_ready), DATA_W'(0));
        check("bp_c_stall", DATA_W'(stall_cnt), DATA_W'(2));
        tick();
        check("bp_c2_stall", DATA_W'(stall_cnt), DATA_W'(3));
        out_ready = 1'b1;
        tick();
        expect_entry("bp_rel_b", CODE_B, 6'h12);
        check("bp_rel_b_rdy", DATA_W'(in_ready), DATA_W'(1));
        tick();
        expect_entry("bp_rel_c", CODE_C, 6'h13);
        drive(1'b0, 32'h0, 6'h00);
        tick();
        expect_bubble("bp_drained");
        check("bp_drained_stall", DATA_W'(stall_cnt), DATA_W'(3));

        // Flush with both entries held and a simultaneous in_valid
        out_ready = 1'b0;
        drive(1'b1, CODE_A, 6'h31);
        tick();
        drive(1'b1, CODE_B, 6'h32);
        tick();
        check("fl_pre_rdy", DATA_W'(in_ready), DATA_W'(0));
        drive(1'b1, CODE_C, 6'h33);
        flush = 1'b1;
        tick();
        expect_bubble("flush");
        check("flush_rdy", DATA_W'(in_ready), DATA_W'(1));
        check("flush_stall", DATA_W'(stall_cnt), DATA_W'(5));
        // Accepted-but-flushed input must vanish
        drive(1'b1, CODE_D, 6'h34);
        tick();
        expect_bubble("flush_drop");
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 6'h00);
        tick();
        expect_bubble("flush_after");
        check("flush_after_rdy", DATA_W'(in_ready), DATA_W'(1));

        // Saturation of the 4-bit stall counter
        out_ready = 1'b0;
        drive(1'b1, CODE_D, 6'h3F);
        tick();
        drive(1'b0, 32'h0, 6'h00);
        for (int i = 0; i < 20; i++) tick();
        check("sat_stall", DATA_W'(stall_cnt), DATA_W'(15));
        expect_entry("sat_entry", CODE_D, 6'h3F);
        tick();
        check("sat_hold", DATA_W'(stall_cnt), DATA_W'(15));

        // Reset with both entries held
        drive(1'b1, CODE_A, 6'h01);
        tick();
        check("rs_skid_rdy", DATA_W'(in_ready), DATA_W'(0));
        rst = 1'b1;
        tick();
        expect_bubble("rs");
        check("rs_rdy", DATA_W'(in_ready), DATA_W'(0));
        check("rs_stall", DATA_W'(stall_cnt), DATA_W'(0));
        rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 6'h00);
        tick();
        expect_bubble("rs_after");
        check("rs_after_rdy", DATA_W'(in_ready), DATA_W'(1));
        tick();
        expect_bubble("rs_after2");
        check("rs_after2_stall", DATA_W'(stall_cnt), DATA_W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
